// File: rtl/md_sched_if.sv
// Issue/operand/result bundle between the E-stage decode and the HI/LO multiply/divide unit.
interface md_sched_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] RSE;
  logic [31:0] RTE;
  logic        MTHI;
  logic        MTLO;
  logic        UseMD_D;
  logic        Busy;
  logic        Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, RSE, RTE, MTHI, MTLO, UseMD_D,
    input  Busy, Stall_MD, HI, LO
  );

  modport slave (
    input  Start, Op, RSE, RTE, MTHI, MTLO, UseMD_D,
    output Busy, Stall_MD, HI, LO
  );
endinterface

// File: rtl/md_sched.sv
// Fixed-latency MIPS multiply/divide sequencer owning HI/LO; raises the D-stage stall
// while an HI/LO-dependent instruction would collide with an in-flight operation.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       Clk,
  input logic       Reset,
  md_sched_if.slave md
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               uns_p0;
  logic [31:0]        a_p0;
  logic [31:0]        b_p0;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [63:0]        mul_res;
  logic [63:0]        div_res;

  function automatic logic [63:0] mul_calc(input logic uns, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    if (uns) return {32'd0, a} * {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sp = sa * sb;
    return sp;
  endfunction

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  function automatic logic [63:0] div_calc(input logic uns, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {cur_hi, cur_lo};
    if (uns) return {a % b, a / b};
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    return {(a[31] ? -r : r), ((a[31] ^ b[31]) ? -q : q)};
  endfunction

  assign mul_res = mul_calc(uns_p0, a_p0, b_p0);
  assign div_res = div_calc(uns_p0, a_p0, b_p0, hi, lo);

  // Stage p0: operand latch at issue, countdown, commit on the last counted edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      uns_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.Start) begin
            uns_p0 <= md.Op[0];
            a_p0   <= md.RSE;
            b_p0   <= md.RTE;
            busy   <= 1'b1;
            if (md.Op[1]) begin
              state <= ST_DIV;
              cnt   <= CNT_W'(DIV_CYCLES);
            end else begin
              state <= ST_MUL;
              cnt   <= CNT_W'(MULT_CYCLES);
            end
          end else begin
            if (md.MTHI) hi <= md.RSE;
            if (md.MTLO) lo <= md.RSE;
          end
        end
        default: begin
          if (cnt == CNT_W'(1)) begin
            {hi, lo} <= (state == ST_DIV) ? div_res : mul_res;
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign md.Busy     = busy;
  assign md.HI       = hi;
  assign md.LO       = lo;
  assign md.Stall_MD = md.UseMD_D & (busy | md.Start);
endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched against a plain-arithmetic HI/LO model.
module tb_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic Clk;
  logic Reset;
  md_sched_if mif ();

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .md   (mif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = 0;
  logic [31:0] model_lo = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: HI/LO from MIPS arithmetic rules, written with native integer types.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint          sp;
    longint unsigned up;
    int              sq;
    int              sr;
    case (op)
      2'b00: begin
        sp = longint'(int'(a)) * longint'(int'(b));
        return sp;
      end
      2'b01: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        return up;
      end
      2'b10: begin
        if (b == 0) return {h, l};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = int'(a) / int'(b);
        sr = int'(a) % int'(b);
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {h, l};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: a completed busy period is the DUT presenting a result.
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (mif.Busy) busy_cnt++;
      if (prev_busy && !mif.Busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_commit", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("commit_hi", {32'd0, mif.HI}, {32'd0, e.hi});
          chk("commit_lo", {32'd0, mif.LO}, {32'd0, e.lo});
          chk("busy_len", 64'(busy_cnt), 64'(e.cyc));
        end
        busy_cnt = 0;
      end
      prev_busy = mif.Busy;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic mt(input logic wh, input logic wl, input logic [31:0] v);
    mif.Start = 1'b0;
    mif.MTHI  = wh;
    mif.MTLO  = wl;
    mif.RSE   = v;
    step();
    mif.MTHI = 1'b0;
    mif.MTLO = 1'b0;
    if (wh) model_hi = v;
    if (wl) model_lo = v;
    chk("mt_hilo", {mif.HI, mif.LO}, {model_hi, model_lo});
  endtask

  // Issue one op from IDLE; poke adds MTHI with Start, then MTHI + a stray Start while busy.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_md, input logic poke);
    logic [63:0] r;
    exp_t        e;
    int          n;
    int          cyc;
    r     = ref_result(op, a, b, model_hi, model_lo);
    n     = op[1] ? DC : MC;
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.cyc = n;
    mif.Start   = 1'b1;
    mif.Op      = op;
    mif.RSE     = a;
    mif.RTE     = b;
    mif.UseMD_D = use_md;
    mif.MTHI    = poke;
    #1;
    chk("stall_start", {63'd0, mif.Stall_MD}, {63'd0, use_md});
    sb_q.push_back(e);
    step();
    mif.Start = 1'b0;
    mif.MTHI  = 1'b0;
    cyc = 0;
    while (mif.Busy && cyc < 64) begin
      chk("stall_busy", {63'd0, mif.Stall_MD}, {63'd0, use_md});
      chk("hilo_stable", {mif.HI, mif.LO}, {model_hi, model_lo});
      if (poke && cyc == 2) begin
        mif.MTHI  = 1'b1;
        mif.MTLO  = 1'b1;
        mif.Start = 1'b1;
        mif.Op    = ~op;
        mif.RSE   = 32'hDEAD_BEEF;
      end else begin
        mif.MTHI  = 1'b0;
        mif.MTLO  = 1'b0;
        mif.Start = 1'b0;
      end
      step();
      cyc++;
    end
    mif.MTHI  = 1'b0;
    mif.MTLO  = 1'b0;
    mif.Start = 1'b0;
    chk("busy_cycles", 64'(cyc), 64'(n));
    model_hi = e.hi;
    model_lo = e.lo;
    #1;
    chk("stall_after", {63'd0, mif.Stall_MD}, 64'd0);
    mif.UseMD_D = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    mif.Start   = 1'b0;
    mif.Op      = 2'b00;
    mif.RSE     = '0;
    mif.RTE     = '0;
    mif.MTHI    = 1'b0;
    mif.MTLO    = 1'b0;
    mif.UseMD_D = 1'b0;
    Reset       = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy", {63'd0, mif.Busy}, 64'd0);
    chk("reset_hilo", {mif.HI, mif.LO}, 64'd0);
    chk("reset_stall", {63'd0, mif.Stall_MD}, 64'd0);
    Reset = 1'b1;
    step();

    mif.UseMD_D = 1'b1;
    #1;
    chk("stall_idle", {63'd0, mif.Stall_MD}, 64'd0);
    mif.UseMD_D = 1'b0;

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("mult_const", {mif.HI, mif.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    chk("multu_const", {mif.HI, mif.LO}, 64'h0000_0002_FFFF_FFFA);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("div_const", {mif.HI, mif.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_const", {mif.HI, mif.LO}, 64'h0000_0001_0000_0003);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_const", {mif.HI, mif.LO}, 64'h0000_0000_8000_0000);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    do_op(2'b10, 32'h1234, 32'd0, 1'b1, 1'b1);
    chk("div0_const", {mif.HI, mif.LO}, 64'h0000_0011_0000_0022);
    mt(1'b1, 1'b1, 32'h5A5A_0001);

    // Abort a DIV three cycles in.
    mif.Start = 1'b1;
    mif.Op    = 2'b10;
    mif.RSE   = 32'd100;
    mif.RTE   = 32'd7;
    step();
    mif.Start = 1'b0;
    step();
    step();
    Reset = 1'b0;
    #1;
    chk("abort_busy", {63'd0, mif.Busy}, 64'd0);
    chk("abort_hilo", {mif.HI, mif.LO}, 64'd0);
    sb_q.delete();
    model_hi = 0;
    model_lo = 0;
    step();
    step();
    Reset = 1'b1;
    repeat (15) step();
    chk("post_abort_hilo", {mif.HI, mif.LO}, 64'd0);
    chk("post_abort_busy", {63'd0, mif.Busy}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), 1'b1, $urandom());
      do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
Multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU issued from E with already-forwarded operands and holds the unit busy for a fixed latency. It owns the HI/LO registers and raises the D-stage stall when an HI/LO-dependent instruction would issue while the unit is occupied.

Parameters:
MULT_CYCLES, 5, cycles from Start edge to HI/LO commit for MULT/MULTU (>=1)
DIV_CYCLES, 10, cycles from Start edge to HI/LO commit for DIV/DIVU (>=1)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  one-cycle issue pulse from E-stage decode
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start
RSE  input  32  forwarded RS operand (dividend / multiplicand)
RTE  input  32  forwarded RT operand (divisor / multiplier)
MTHI  input  1  write RSE into HI this cycle
MTLO  input  1  write RSE into LO this cycle
UseMD_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
Busy  output  1  unit occupied
Stall_MD  output  1  freeze F/D, bubble into E
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset low (async): state IDLE, counter 0, HI=0, LO=0, Busy=0, operand latches 0. Aborts any in-flight op; no commit after release.
- States: IDLE, MUL, DIV. Busy = (state != IDLE), registered.
- IDLE + Start at edge k: latch RSE, RTE, Op; counter <= MULT_CYCLES or DIV_CYCLES; go MUL (Op[1]=0) or DIV (Op[1]=1). Busy high from edge k through edge k+N, i.e. N cycles.
- MUL/DIV: counter decrements each edge; at edge where counter==1, commit HI/LO from latched operands, return IDLE. Commit occurs at edge k+N; Busy low in the following cycle.
- Start while Busy: ignored (pipeline guarantees stall; no state change).
- MTHI/MTLO: honoured only in IDLE with Start low; HI/LO <= RSE at that edge, no busy period. Ignored while Busy or when Start is high in the same cycle (Start wins). MTHI and MTLO together write both.
- Arithmetic: MULT = signed 32x32->64; MULTU = unsigned; HI = upper 32, LO = lower 32.
- DIV: signed, quotient truncated toward zero -> LO, remainder takes dividend sign -> HI. DIVU: unsigned.
- Divisor 0: full busy period still elapses; HI/LO unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Stall_MD = UseMD_D & (Busy | Start), combinational. No other output is combinational.
- HI/LO are stable during Busy (old values visible until commit).

Test Plan:
- MULT RSE=0xFFFFFFFE, RTE=3, Start at edge 0 -> Busy high for 5 cycles; at edge 5 HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy=0 after.
- MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA at edge 5.
- DIV RSE=0xFFFFFFF9 (-7), RTE=2 -> at edge 10 LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- Divisor 0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> Busy 10 cycles, HI=0x11, LO=0x22 afterward; MTHI during Busy ignored.
- UseMD_D=1 during DIV busy -> Stall_MD=1 every busy cycle and in the Start cycle; Stall_MD=0 once Busy falls; UseMD_D=0 -> Stall_MD=0 throughout.
- Reset pulled low at cycle 3 of a DIV -> HI=LO=0, Busy=0 immediately; no commit after Reset rises; Start ignored while Busy, second op issues only from IDLE.
